// File: rtl/generic_bus_arbiter.sv
// generic_bus_arbiter
//   Shares one generic_bus slave (RAM / memory controller) between two
//   cpu-side requesters: port 0 = data side, port 1 = instruction side.
//   One requester is granted at a time. The grant is held until the slave
//   completes the access (request high, s_busy low) or the requester drops
//   its request (abort). The FSM returns to IDLE after every grant, so each
//   transaction costs one arbitration cycle.
//
//   Optional feature (macro ARB_ROUND_ROBIN_EN):
//     defined   - round-robin on simultaneous requests, using a last-grant bit
//                 that resets to 1 so the first contested grant goes to port 0
//     undefined - fixed priority, port 0 wins simultaneous requests
//
// Ports
//   CLK, nRST                         clock, asynchronous active-low reset
//   mK_addr/ren/wen/wdata/byte_en     requester K access (K = 0, 1)
//   mK_rdata                          slave read data (broadcast to both ports)
//   mK_busy                           stall to requester K
//   s_addr/ren/wen/wdata/byte_en      access forwarded to the slave
//   s_rdata, s_busy                   slave response
module generic_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // requester 0 (data side)
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_ren,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_byte_en,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_busy,
  // requester 1 (instruction side)
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_ren,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_byte_en,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_busy,
  // slave side
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_ren,
  output logic              s_wen,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_byte_en,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic req0, req1;
  logic both_pick1;  // winner of a simultaneous request: 1 = requester 1

  assign req0 = m0_ren | m0_wen;
  assign req1 = m1_ren | m1_wen;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Grant the requester that was not served last.
  assign both_pick1 = ~last_grant_q;
`else
  assign both_pick1 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = both_pick1 ? GRANT1 : GRANT0;
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
      end
      // Leave on completion (request with slave not busy) or on abort.
      GRANT0: if (!req0 || !s_busy) state_d = IDLE;
      GRANT1: if (!req1 || !s_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      // Every exit from a grant (completion or abort) records its owner.
      if (state_q == GRANT0 && state_d == IDLE) last_grant_q <= 1'b0;
      if (state_q == GRANT1 && state_d == IDLE) last_grant_q <= 1'b1;
`endif
    end
  end

  // Slave mux and stall generation. Each requester's busy depends only on the
  // registered state and s_busy, never on the other requester's inputs.
  always_comb begin
    s_addr    = '0;
    s_ren     = 1'b0;
    s_wen     = 1'b0;
    s_wdata   = '0;
    s_byte_en = '0;
    m0_busy   = 1'b1;
    m1_busy   = 1'b1;
    unique case (state_q)
      GRANT0: begin
        s_addr    = m0_addr;
        s_ren     = m0_ren;
        s_wen     = m0_wen;
        s_wdata   = m0_wdata;
        s_byte_en = m0_byte_en;
        m0_busy   = s_busy;
      end
      GRANT1: begin
        s_addr    = m1_addr;
        s_ren     = m1_ren;
        s_wen     = m1_wen;
        s_wdata   = m1_wdata;
        s_byte_en = m1_byte_en;
        m1_busy   = s_busy;
      end
      default: ;
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
module tb_generic_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [AW-1:0] maddr  [2];
  logic          mren   [2];
  logic          mwen   [2];
  logic [DW-1:0] mwdata [2];
  logic [3:0]    mbe    [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_busy, m1_busy;
  logic [AW-1:0] s_addr;
  logic          s_ren, s_wen;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_byte_en;
  logic [DW-1:0] s_rdata;
  logic          s_busy;

  generic_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .m0_addr(maddr[0]), .m0_ren(mren[0]), .m0_wen(mwen[0]), .m0_wdata(mwdata[0]),
    .m0_byte_en(mbe[0]), .m0_rdata(m0_rdata), .m0_busy(m0_busy),
    .m1_addr(maddr[1]), .m1_ren(mren[1]), .m1_wen(mwen[1]), .m1_wdata(mwdata[1]),
    .m1_byte_en(mbe[1]), .m1_rdata(m1_rdata), .m1_busy(m1_busy),
    .s_addr(s_addr), .s_ren(s_ren), .s_wen(s_wen), .s_wdata(s_wdata),
    .s_byte_en(s_byte_en), .s_rdata(s_rdata), .s_busy(s_busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: owner = -1 when nobody holds the bus, else the port index.
  int owner;
  int last;
  int grants[$];  // log of granted ports, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_busy(input int k);
    return (owner == k) ? s_busy : 1'b1;
  endfunction

  function automatic logic req(input int k);
    return mren[k] | mwen[k];
  endfunction

  task automatic check_outputs();
    if (owner < 0) begin
      chk("s_addr", s_addr, 32'h0);
      chk("s_ren", {31'b0, s_ren}, 32'h0);
      chk("s_wen", {31'b0, s_wen}, 32'h0);
      chk("s_wdata", s_wdata, 32'h0);
      chk("s_byte_en", {28'b0, s_byte_en}, 32'h0);
    end else begin
      chk("s_addr", s_addr, maddr[owner]);
      chk("s_ren", {31'b0, s_ren}, {31'b0, mren[owner]});
      chk("s_wen", {31'b0, s_wen}, {31'b0, mwen[owner]});
      chk("s_wdata", s_wdata, mwdata[owner]);
      chk("s_byte_en", {28'b0, s_byte_en}, {28'b0, mbe[owner]});
    end
    chk("m0_busy", {31'b0, m0_busy}, {31'b0, exp_busy(0)});
    chk("m1_busy", {31'b0, m1_busy}, {31'b0, exp_busy(1)});
    chk("m0_rdata", m0_rdata, s_rdata);
    chk("m1_rdata", m1_rdata, s_rdata);
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
  endtask

  // Arbitration decision taken at the coming rising edge.
  task automatic model_update();
    if (!nRST) begin
      model_reset();
    end else if (owner < 0) begin
      if (req(0) && req(1)) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner = 1 - last;
`else
        owner = 0;
`endif
      end else if (req(0)) owner = 0;
      else if (req(1)) owner = 1;
      if (owner >= 0) grants.push_back(owner);
    end else if (!req(owner) || !s_busy) begin
      last  = owner;
      owner = -1;
    end
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic settle();
    #2;
    check_outputs();
  endtask

  task automatic advance();
    model_update();
    @(negedge CLK);
  endtask

  task automatic set_req(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    mren[k] = r; mwen[k] = w; maddr[k] = a; mwdata[k] = d; mbe[k] = be;
  endtask

  logic active[2];
  logic done[2];

  initial begin
    nRST = 1'b0;
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_busy  = 1'b0;
    s_rdata = 32'hA5A5_0000;
    model_reset();
    @(negedge CLK);

    // Reset state, with a request pending that must not be granted.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    settle();
    chk("rst_m0_busy", {31'b0, m0_busy}, 32'h1);
    chk("rst_s_ren", {31'b0, s_ren}, 32'h0);
    advance();
    settle();
    advance();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nRST = 1'b1;
    settle(); advance();

    // Single zero-wait read by requester 0.
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    s_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_c1_m0_busy", {31'b0, m0_busy}, 32'h1);
    advance();
    settle();
    chk("rd_c2_s_ren", {31'b0, s_ren}, 32'h1);
    chk("rd_c2_m0_busy", {31'b0, m0_busy}, 32'h0);
    chk("rd_c2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_m1_busy", {31'b0, m1_busy}, 32'h1);
    advance();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle(); advance();

    // Write with three slave wait states by requester 1.
    set_req(1, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    s_busy = 1'b1;
    settle(); advance();
    for (int i = 0; i < 4; i++) begin
      s_busy = (i < 3);
      settle();
      chk("wr_s_addr", s_addr, 32'h80);
      chk("wr_s_wdata", s_wdata, 32'h1234_5678);
      chk("wr_m1_busy", {31'b0, m1_busy}, (i < 3) ? 32'h1 : 32'h0);
      advance();
    end
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    chk("wr_idle_s_wen", {31'b0, s_wen}, 32'h0);
    advance();

    // Both requesters read continuously against a zero-wait slave.
    s_busy = 1'b0;
    grants.delete();
    set_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    for (int i = 0; i < 12; i++) begin settle(); advance(); end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle(); advance();
    chk("sim_grant_count", grants.size(), 32'd6);
    for (int i = 0; i < grants.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("sim_grant_seq", grants[i], i % 2);
`else
      chk("sim_grant_seq", grants[i], 32'd0);
`endif
    end

    // Abort: requester 0 drops its read while the slave is busy.
    s_busy = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    settle(); advance();
    set_req(1, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    settle();
    chk("ab_g0_s_addr", s_addr, 32'h500);
    advance();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle(); advance();
    settle();
    chk("ab_idle_s_ren", {31'b0, s_ren}, 32'h0);
    advance();
    settle();
    chk("ab_g1_s_addr", s_addr, 32'h600);
    s_busy = 1'b0;
    advance();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle(); advance();

    // Reset in the middle of a busy read.
    s_busy = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    settle(); advance();
    settle();
    chk("rm_pre_s_ren", {31'b0, s_ren}, 32'h1);
    nRST = 1'b0;
    #1;
    chk("rm_s_ren", {31'b0, s_ren}, 32'h0);
    chk("rm_m0_busy", {31'b0, m0_busy}, 32'h1);
    chk("rm_m1_busy", {31'b0, m1_busy}, 32'h1);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    settle(); advance();
    settle();
    chk("rm_regrant_s_addr", s_addr, 32'h100);
    s_busy = 1'b0;
    advance();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle(); advance();

    // Random traffic against the reference model.
    active[0] = 1'b0; active[1] = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (active[k] && (done[k] || ($urandom % 20) == 0)) begin
          active[k] = 1'b0;
          set_req(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end else if (!active[k] && ($urandom % 3) == 0) begin
          logic [1:0] rw;
          rw = 2'($urandom_range(1, 3));
          active[k] = 1'b1;
          set_req(k, rw[0], rw[1], $urandom, $urandom, 4'($urandom));
        end
      end
      s_busy  = ($urandom % 2) == 0;
      s_rdata = $urandom;
      settle();
      for (int k = 0; k < 2; k++) done[k] = req(k) && !exp_busy(k);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
